// File: rtl/stb_seq_ctrl.sv
// Strobe acquisition sequencer: runs a burst of strobe requests,
// settles, samples the comparator and supervises timeouts and errors.
module stb_seq_ctrl #(
  parameter int N_WIDTH       = 16,
  parameter int TO_WIDTH      = 24,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [N_WIDTH-1:0]  num_samples_i,
  input  logic [TO_WIDTH-1:0] timeout_i,
  input  logic                gen_rdy_i,
  input  logic                gen_err_i,
  input  logic                stb_valid_i,
  input  logic [31:0]         stb_period_i,
  input  logic                cmp_i,
  output logic                stb_req_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic [N_WIDTH-1:0]  hit_cnt_o,
  output logic [N_WIDTH-1:0]  smp_cnt_o,
  output logic [31:0]         period_o
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, REQ, WAIT_ACK, WAIT_VALID,
    SETTLE, SAMPLE, DONE, ERR
  } state_t;

  state_t              state, state_nxt;
  logic [N_WIDTH-1:0]  n_cap, n_cap_nxt;
  logic [TO_WIDTH-1:0] to_cap, to_cap_nxt;
  logic [TO_WIDTH-1:0] tmo_cnt, tmo_nxt;
  logic [SW-1:0]       settle_cnt, settle_nxt;
  logic                req_nxt, busy_nxt, done_nxt, err_nxt;
  logic [1:0]          code_nxt;
  logic [N_WIDTH-1:0]  hit_nxt, smp_nxt;
  logic [31:0]         period_nxt;

  logic                active, tmo_hit, wait_nxt;
  logic [N_WIDTH-1:0]  smp_inc, hit_inc;

  assign active = state inside {WAIT_RDY, REQ, WAIT_ACK,
                                WAIT_VALID, SETTLE, SAMPLE};
  assign tmo_hit = (to_cap != '0) &&
                   (tmo_cnt >= to_cap - TO_WIDTH'(1));
  assign smp_inc = (&smp_cnt_o) ? smp_cnt_o
                                : smp_cnt_o + N_WIDTH'(1);
  assign hit_inc = (&hit_cnt_o) ? hit_cnt_o
                                : hit_cnt_o + N_WIDTH'(1);

  always_comb begin
    state_nxt  = state;
    n_cap_nxt  = n_cap;
    to_cap_nxt = to_cap;
    settle_nxt = settle_cnt;
    err_nxt    = err_o;
    code_nxt   = err_code_o;
    hit_nxt    = hit_cnt_o;
    smp_nxt    = smp_cnt_o;
    period_nxt = period_o;
    if (active && abort_i) begin
      state_nxt = IDLE;
    end else if (active && gen_err_i) begin
      state_nxt = ERR;
      code_nxt  = 2'd1;
    end else begin
      unique case (state)
        IDLE: if (start_i) begin
          err_nxt    = 1'b0;
          code_nxt   = 2'd0;
          hit_nxt    = '0;
          smp_nxt    = '0;
          n_cap_nxt  = num_samples_i;
          to_cap_nxt = timeout_i;
          state_nxt  = (num_samples_i == '0) ? DONE : WAIT_RDY;
        end
        WAIT_RDY: if (gen_rdy_i) begin
          period_nxt = stb_period_i;
          state_nxt  = REQ;
        end else if (tmo_hit) begin
          state_nxt = ERR;
          code_nxt  = 2'd2;
        end
        REQ: state_nxt = WAIT_ACK;
        WAIT_ACK: if (!stb_valid_i) begin
          state_nxt = WAIT_VALID;
        end else if (tmo_hit) begin
          state_nxt = ERR;
          code_nxt  = 2'd3;
        end
        WAIT_VALID: if (stb_valid_i) begin
          state_nxt  = SETTLE;
          settle_nxt = SW'(SETTLE_CYCLES - 1);
        end else if (tmo_hit) begin
          state_nxt = ERR;
          code_nxt  = 2'd3;
        end
        SETTLE: if (settle_cnt == '0) begin
          state_nxt = SAMPLE;
        end else begin
          settle_nxt = settle_cnt - SW'(1);
        end
        SAMPLE: begin
          smp_nxt   = smp_inc;
          if (cmp_i) hit_nxt = hit_inc;
          state_nxt = (smp_inc == n_cap) ? DONE : REQ;
        end
        DONE:    state_nxt = IDLE;
        ERR:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // Each wait state gets a fresh timeout window on entry
    wait_nxt = state_nxt inside {WAIT_RDY, WAIT_ACK, WAIT_VALID};
    tmo_nxt  = tmo_cnt;
    if (wait_nxt && state_nxt != state) begin
      tmo_nxt = '0;
    end else if (wait_nxt && !(&tmo_cnt)) begin
      tmo_nxt = tmo_cnt + TO_WIDTH'(1);
    end

    req_nxt  = (state_nxt == REQ);
    done_nxt = (state_nxt == DONE);
    busy_nxt = !(state_nxt inside {IDLE, DONE, ERR});
    if (state_nxt == ERR) err_nxt = 1'b1;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      n_cap      <= '0;
      to_cap     <= '0;
      tmo_cnt    <= '0;
      settle_cnt <= '0;
      stb_req_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= 2'd0;
      hit_cnt_o  <= '0;
      smp_cnt_o  <= '0;
      period_o   <= '0;
    end else begin
      state      <= state_nxt;
      n_cap      <= n_cap_nxt;
      to_cap     <= to_cap_nxt;
      tmo_cnt    <= tmo_nxt;
      settle_cnt <= settle_nxt;
      stb_req_o  <= req_nxt;
      busy_o     <= busy_nxt;
      done_o     <= done_nxt;
      err_o      <= err_nxt;
      err_code_o <= code_nxt;
      hit_cnt_o  <= hit_nxt;
      smp_cnt_o  <= smp_nxt;
      period_o   <= period_nxt;
    end
  end

endmodule
